// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches with at most one request
// in flight and buffers returned instructions with their PCs until IF/ID takes them.
module fetch_queue #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DEPTH      = 4,
    parameter int                    PC_INC     = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [ADDR_WIDTH-1:0]    redirect_pc,
    input  logic                     halt,
    output logic                     imem_req,
    output logic [ADDR_WIDTH-1:0]    imem_addr,
    input  logic                     imem_valid,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_instr,
    output logic [ADDR_WIDTH-1:0]    out_pc,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int                    PTR_W   = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(PC_INC);
    localparam logic [PTR_W+1:0]      DEPTH_W = (PTR_W + 2)'(DEPTH);

    logic [ADDR_WIDTH-1:0] fetchPc;
    logic [ADDR_WIDTH-1:0] outstandingPc;
    logic                  outstanding;
    logic [PTR_W:0]        rdPtr;
    logic [PTR_W:0]        wrPtr;
    logic [PTR_W-1:0]      rdIdx;
    logic [PTR_W-1:0]      wrIdx;
    logic [PTR_W+1:0]      inUse;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  alignErr;

    logic [DATA_WIDTH-1:0] instrMem [DEPTH];
    logic [ADDR_WIDTH-1:0] pcMem    [DEPTH];

    assign rdIdx = rdPtr[PTR_W-1:0];
    assign wrIdx = wrPtr[PTR_W-1:0];

    // The wrap bit makes full and empty distinguishable, so occupancy is a plain difference.
    assign count = wrPtr - rdPtr;
    assign inUse = {1'b0, count} + {{(PTR_W + 1){1'b0}}, outstanding};

    // A slot is reserved for the in-flight response, so a push never lands on a full queue.
    assign issue = !redirect && !halt && !rst && (!outstanding || imem_valid) && (inUse < DEPTH_W);
    assign push  = imem_valid && outstanding && !redirect;
    assign pop   = out_valid && out_ready && !redirect;

    assign alignErr = redirect && ((redirect_pc % PC_STEP) != '0);

    assign imem_req  = issue;
    assign imem_addr = fetchPc;
    assign out_valid = (count != '0);

    // NOTE: storage is not reset; masking the head with out_valid gives the zero reset value instead.
    assign out_instr = out_valid ? instrMem[rdIdx] : '0;
    assign out_pc    = out_valid ? pcMem[rdIdx]    : '0;

    // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPc       <= RESET_PC;
            outstandingPc <= RESET_PC;
            outstanding   <= 1'b0;
            rdPtr         <= '0;
            wrPtr         <= '0;
            err           <= 1'b0;
        end else begin
            if ((imem_valid && !outstanding) || alignErr) begin
                err <= 1'b1;
            end

            if (redirect) begin
                fetchPc     <= redirect_pc;
                outstanding <= 1'b0;
                rdPtr       <= '0;
                wrPtr       <= '0;
            end else begin
                if (push) begin
                    wrPtr <= wrPtr + 1'b1;
                end
                if (pop) begin
                    rdPtr <= rdPtr + 1'b1;
                end
                if (issue) begin
                    outstandingPc <= fetchPc;
                    fetchPc       <= fetchPc + PC_STEP;
                    outstanding   <= 1'b1;
                end else if (imem_valid) begin
                    outstanding <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instrMem[wrIdx] <= imem_rdata;
            pcMem[wrIdx]    <= outstandingPc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised self-checking bench for fetch_queue against a queue-level reference model
// with a one-cycle-latency memory that returns the inverted fetch address.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic        out_ready = 1'b0;
    logic [2:0]  count;
    logic        err;

    fetch_queue dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_ready   (out_ready),
        .count       (count),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } entryT;

    entryT       mQ[$];
    logic [15:0] mFetchPc = '0;
    logic [15:0] mInflightPc = '0;
    bit          mInflight = 1'b0;
    bit          mErr = 1'b0;
    bit          memValid = 1'b0;
    logic [15:0] memData = '0;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mQ.delete();
        mFetchPc    = 16'h0000;
        mInflightPc = 16'h0000;
        mInflight   = 1'b0;
        mErr        = 1'b0;
    endtask

    // Called in the low clock phase; rst rises mid-phase and falls at the next negedge.
    task automatic applyReset(input bit clearPending);
        #2;
        rst        = 1'b1;
        redirect   = 1'b0;
        halt       = 1'b0;
        imem_valid = 1'b0;
        modelReset();
        if (clearPending) memValid = 1'b0;
        #1;
        check("rst_imem_req",  32'(imem_req),  32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'h0000);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", 32'(out_instr), 32'd0);
        check("rst_out_pc",    32'(out_pc),    32'd0);
        check("rst_count",     32'(count),     32'd0);
        check("rst_err",       32'(err),       32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle: drive at negedge, check, advance the model, return at next negedge.
    task automatic step(input bit redir, input logic [15:0] rpc, input bit hlt,
                        input bit rdy, input bit spurious);
        bit          vld;
        bit          expReq;
        logic [15:0] reqAddr;
        redirect    = redir;
        redirect_pc = rpc;
        halt        = hlt;
        out_ready   = rdy;
        vld         = memValid | spurious;
        imem_valid  = vld;
        imem_rdata  = memData;
        #1;
        expReq  = !redir && !hlt && (!mInflight || vld) && ((mQ.size() + int'(mInflight)) < DEPTH);
        reqAddr = mFetchPc;
        check("imem_req",  32'(imem_req),  32'(expReq));
        check("imem_addr", 32'(imem_addr), 32'(reqAddr));
        check("out_valid", 32'(out_valid), 32'(mQ.size() > 0));
        check("count",     32'(count),     32'(mQ.size()));
        check("err",       32'(err),       32'(mErr));
        if (mQ.size() > 0) begin
            check("out_pc",    32'(out_pc),    32'(mQ[0].pc));
            check("out_instr", 32'(out_instr), 32'(mQ[0].instr));
        end

        if ((vld && !mInflight) || (redir && ((rpc % 16'd2) != 16'd0))) mErr = 1'b1;
        if (redir) begin
            mQ.delete();
            mInflight = 1'b0;
            mFetchPc  = rpc;
        end else begin
            if (mQ.size() > 0 && rdy) void'(mQ.pop_front());
            if (vld && mInflight) mQ.push_back('{instr: imem_rdata, pc: mInflightPc});
            if (expReq) begin
                mInflightPc = mFetchPc;
                mFetchPc    = mFetchPc + 16'd2;
                mInflight   = 1'b1;
            end else if (vld) begin
                mInflight = 1'b0;
            end
        end
        memValid = expReq;
        memData  = ~reqAddr;
        @(negedge clk);
    endtask

    initial begin
        bit reached;

        applyReset(1'b1);

        // Fill with the consumer stalled: four requests, then the queue holds.
        repeat (8) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        check("fill_count", 32'(count), 32'd4);
        check("fill_head",  32'(out_pc), 32'h0000);

        // Streaming.
        repeat (20) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        // Build three entries with a request in flight, then redirect.
        reached = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mQ.size() == 3 && mInflight) begin
                reached = 1'b1;
                break;
            end
            step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        end
        check("fill3_reached", 32'(reached), 32'd1);
        step(1'b1, 16'h0100, 1'b0, 1'b1, 1'b0);
        check("redir_count", 32'(count), 32'd0);
        repeat (6) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        // Halt mid-stream, then resume.
        repeat (5) step(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
        check("halt_drained", 32'(out_valid), 32'd0);
        repeat (8) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        // Address wrap.
        step(1'b1, 16'hFFFC, 1'b0, 1'b1, 1'b0);
        repeat (8) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        // Random traffic with aligned redirects.
        repeat (500) begin
            step($urandom_range(15) == 0, 16'($urandom) & 16'hFFFE,
                 $urandom_range(5) == 0, $urandom_range(9) < 7, 1'b0);
        end

        // Asynchronous reset with a response still in flight.
        repeat (3) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        applyReset(1'b0);
        repeat (4) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        // Misaligned redirect target.
        applyReset(1'b1);
        repeat (2) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h0003, 1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        check("err_misaligned", 32'(err), 32'd1);

        // Spurious response with nothing outstanding.
        applyReset(1'b1);
        repeat (2) step(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b1, 1'b1);
        repeat (4) step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        check("err_spurious", 32'(err), 32'd1);

        applyReset(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
